// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two-master request/grant/read-return bundle plus the single RAM port.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          m0_req;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_we;
   logic          m0_gnt;
   logic [DW-1:0] m0_rdata;
   logic          m0_rvalid;
   logic          m1_req;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_we;
   logic          m1_gnt;
   logic [DW-1:0] m1_rdata;
   logic          m1_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  m0_req, m0_addr, m0_wdata, m0_we,
      output m0_gnt, m0_rdata, m0_rvalid,
      input  m1_req, m1_addr, m1_wdata, m1_we,
      output m1_gnt, m1_rdata, m1_rvalid,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_addr, m0_wdata, m0_we,
      input  m0_gnt, m0_rdata, m0_rvalid,
      output m1_req, m1_addr, m1_wdata, m1_we,
      input  m1_gnt, m1_rdata, m1_rvalid,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, burst-bounded sharing of one single-port RAM between two masters,
// with read data tagged back to the issuing master after the RAM's fixed latency.
module mem_arbiter #(
   parameter int AW        = 16,
   parameter int DW        = 16,
   parameter int RD_LAT    = 1,
   parameter int BURST_MAX = 8
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.slave  bus
);
   localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [CW-1:0] C_TOP = CW'(BURST_MAX - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t            r_state, w_next;
   logic              r_last;
   logic [CW-1:0]     r_burst, w_burst;
   logic [RD_LAT-1:0] r_pv, r_pid, w_pv, w_pid;
   logic              w_own0, w_own1, w_oreq, w_xreq, w_we, w_push;

   assign w_own0 = (r_state == OWN0);
   assign w_own1 = (r_state == OWN1);
   assign w_oreq = w_own0 ? bus.m0_req : (w_own1 & bus.m1_req);
   assign w_xreq = w_own0 ? bus.m1_req : (w_own1 & bus.m0_req);
   assign w_we   = w_own0 ? bus.m0_we  : (w_own1 & bus.m1_we);
   assign w_push = w_oreq & ~w_we;

   assign bus.m0_gnt    = w_own0;
   assign bus.m1_gnt    = w_own1;
   assign bus.mem_addr  = w_own0 ? bus.m0_addr  : w_own1 ? bus.m1_addr  : '0;
   assign bus.mem_wdata = w_own0 ? bus.m0_wdata : w_own1 ? bus.m1_wdata : '0;
   assign bus.mem_we    = w_oreq & w_we;
   assign bus.m0_rdata  = bus.mem_rdata;
   assign bus.m1_rdata  = bus.mem_rdata;
   assign bus.m0_rvalid = r_pv[RD_LAT-1] & ~r_pid[RD_LAT-1];
   assign bus.m1_rvalid = r_pv[RD_LAT-1] &  r_pid[RD_LAT-1];

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (bus.m0_req & bus.m1_req) ? (r_last ? OWN0 : OWN1) :
                           bus.m0_req ? OWN0 : bus.m1_req ? OWN1 : IDLE;
         OWN0:    w_next = (bus.m1_req & (~bus.m0_req | (r_burst == C_TOP))) ? OWN1 :
                           (~bus.m0_req & ~bus.m1_req) ? IDLE : OWN0;
         OWN1:    w_next = (bus.m0_req & (~bus.m1_req | (r_burst == C_TOP))) ? OWN0 :
                           (~bus.m0_req & ~bus.m1_req) ? IDLE : OWN1;
         default: w_next = IDLE;
      endcase
      // burst only counts while the other master is actually waiting
      w_burst = ((w_next != r_state) | ~w_xreq) ? '0 :
                (r_burst == C_TOP) ? r_burst : r_burst + 1'b1;
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign w_pv  = w_push;
         assign w_pid = w_own1;
      end else begin : g_latn
         assign w_pv  = {r_pv[RD_LAT-2:0], w_push};
         assign w_pid = {r_pid[RD_LAT-2:0], w_own1};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_burst <= '0;
         r_pv    <= '0;
         r_pid   <= '0;
      end else begin
         r_state <= w_next;
         r_burst <= w_burst;
         r_pv    <= w_pv;
         r_pid   <= w_pid;
         if (w_next == OWN0)
            r_last <= 1'b0;
         else if (w_next == OWN1)
            r_last <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for burst rotation,
// read return across ownership change, and asynchronous reset with a read in flight.
module tb_mem_arbiter;
   logic clk, rst_n;
   int   n_tests, n_fail;

   mem_arbiter_if #(.AW(16), .DW(16)) bus ();

   mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .BURST_MAX(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] ram [0:65535];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one-cycle synchronous RAM
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   typedef struct {
      logic        r0, w0;
      logic [15:0] a0, d0;
      logic        r1, w1;
      logic [15:0] a1, d1;
      logic        g0, g1, v0, v1, we;
      logic [15:0] ma, mw, rd;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.m0_req = v.r0; bus.m0_we = v.w0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
      bus.m1_req = v.r1; bus.m1_we = v.w1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
   endtask

   function automatic logic [1:0] own_bits(input int o);
      return {o == 1, o == 0};
   endfunction

   initial begin
      logic [15:0] rdm;
      int          own, prev;
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
      ram[16'h0010] = 16'hBEEF;
      ram[16'h0020] = 16'h5555;
      ram[16'h0030] = 16'hAAAA;

      //          r0 w0 a0        d0      r1 w1 a1        d1        g0 g1 v0 v1 we ma        mw        rd
      tbl[0]  = '{0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
      tbl[1]  = '{1, 0, 16'h0010, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
      tbl[2]  = '{1, 0, 16'h0010, 16'h0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000};
      tbl[3]  = '{0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'hBEEF};
      tbl[4]  = '{0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
      tbl[5]  = '{0, 0, 16'h0000, 16'h0, 1, 1, 16'hD000, 16'h1234, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
      tbl[6]  = '{0, 0, 16'h0000, 16'h0, 1, 1, 16'hD000, 16'h1234, 0, 1, 0, 0, 1, 16'hD000, 16'h1234, 16'h0000};
      tbl[7]  = '{1, 0, 16'hD000, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
      tbl[8]  = '{1, 0, 16'hD000, 16'h0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'hD000, 16'h0000, 16'h0000};
      tbl[9]  = '{0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h1234};
      tbl[10] = '{0, 0, 16'h0000, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};

      rst_n = 1'b0;
      drive(tbl[0]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_we, bus.mem_addr},
            {5'b0, 16'h0000});
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         rdm = tbl[i].v0 ? bus.m0_rdata : tbl[i].v1 ? bus.m1_rdata : 16'h0;
         check($sformatf("vec%0d", i),
               {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_we, bus.mem_addr, bus.mem_wdata, rdm},
               {tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1, tbl[i].we, tbl[i].ma, tbl[i].mw, tbl[i].rd});
      end

      // reset with an m0 read in flight; last_owner is currently m0
      @(negedge clk);
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0010;
      @(negedge clk);
      #1 check("rst_pre_gnt", {63'b0, bus.m0_gnt}, 64'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_async", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_we, bus.mem_addr},
               {5'b0, 16'h0000});
      @(negedge clk);
      bus.m0_req = 1'b0; bus.m0_addr = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_no_stale0", {62'b0, bus.m0_rvalid, bus.m1_rvalid}, 64'd0);
      @(negedge clk);
      #1 check("rst_no_stale1", {62'b0, bus.m0_rvalid, bus.m1_rvalid}, 64'd0);

      // both hold read requests: m0 wins the tie, 8/8 rotation, read tags follow issuer
      prev = 2;
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0020;
            bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0030;
         end
         own = (c == 0) ? 2 : (c <= 8) ? 0 : (c <= 16) ? 1 : 0;
         #1;
         rdm = (prev == 0) ? bus.m0_rdata : (prev == 1) ? bus.m1_rdata : 16'h0;
         check($sformatf("rr_cycle%0d", c),
               {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, rdm},
               {own_bits(own) == 2'b01, own_bits(own) == 2'b10,
                prev == 0, prev == 1,
                (prev == 0) ? 16'h5555 : (prev == 1) ? 16'hAAAA : 16'h0000});
         prev = own;
      end

      @(negedge clk);
      bus.m0_req = 1'b0; bus.m1_req = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
